pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline sequencing controller for the 3-stage core (if_stage → id_stage → ex_stage). Owns PC-advance enable, IF/ID stall, ID flush and EX bubble insertion, arbitrating between branch flush, multi-cycle EX busy, load-use hazard and debug halt/resume. It replaces the direct EX→ID flush wire and the bench-driven pc increment, and exposes saturating stall/flush performance counters.

## Interface
- BOOT_CYCLES, 2, cycles held in BOOT after reset release before fetch starts (≥1)
- FLUSH_CYCLES, 2, total cycles id_flush_o is held per taken branch (≥1)
- DRAIN_CYCLES, 2, bubble cycles inserted on halt before entering HALT (≥1)
- BUSY_TIMEOUT, 64, max consecutive ex_busy_i cycles before error
- CNT_W, 16, performance counter width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush_i  in  1  taken branch/jump resolved in EX this cycle
- ex_busy_i  in  1  EX holding its instruction (multi-cycle op)
- ex_mem_read_i  in  1  instruction in EX is a load
- ex_rd_i  in  5  destination register of EX instruction
- id_rs1_i, id_rs2_i  in  5 each  source registers of ID instruction
- id_rs1_used_i, id_rs2_used_i  in  1 each  ID instruction reads rs1/rs2
- halt_req_i  in  1  debug halt request (level)
- resume_i  in  1  debug resume (pulse, sampled in HALT only)
- pc_incr_en_o  out  1  PC advance enable to if_stage
- if_stall_o  out  1  hold IF output register
- id_stall_o  out  1  hold ID pipeline register
- id_flush_o  out  1  replace ID output with NOP
- ex_bubble_o  out  1  EX captures NOP instead of ID bus
- halted_o  out  1  core in HALT
- err_o  out  1  sticky busy-timeout error
- state_o  out  3  current pipe_state_t
- stall_cnt_o, flush_cnt_o  out  CNT_W each  saturating counters

## Operation
- States: BOOT, RUN, FLUSH, BUSY, DRAIN, HALT.
- Load-use hazard (lu) = ex_mem_read_i & ex_rd_i≠0 & ((id_rs1_used_i & id_rs1_i==ex_rd_i) | (id_rs2_used_i & id_rs2_i==ex_rd_i)).
- BOOT: pc_incr_en_o=0, if_stall_o=id_stall_o=1, others 0; counter reaches BOOT_CYCLES-1 → RUN.
- RUN priority per cycle: flush_i > ex_busy_i > lu > halt_req_i.
  - flush_i: id_flush_o=1, ex_bubble_o=1, pc_incr_en_o=1; flush_cnt+1; FLUSH_CYCLES>1 → FLUSH with remaining = FLUSH_CYCLES-1, else stay RUN.
  - ex_busy_i: pc_incr_en_o=0, if_stall_o=id_stall_o=1, ex_bubble_o=0; → BUSY, timer=1.
  - lu: pc_incr_en_o=0, if_stall_o=id_stall_o=1, ex_bubble_o=1; stays RUN (one cycle, clears as load advances).
  - halt_req_i: pc_incr_en_o=0, if_stall_o=1, id_flush_o=1; → DRAIN, count=1.
  - none: pc_incr_en_o=1, all other controls 0.
- FLUSH: id_flush_o=ex_bubble_o=1, pc_incr_en_o=1; decrement; at 1 → RUN. New flush_i here reloads remaining=FLUSH_CYCLES-1, counts again.
- BUSY: outputs as busy entry; ex_busy_i=0 → RUN with RUN outputs that cycle (Mealy); timer reaching BUSY_TIMEOUT → err_o=1, → HALT. flush_i ignored (EX not resolving).
- DRAIN: pc_incr_en_o=0, if_stall_o=1, id_flush_o=ex_bubble_o=1; after DRAIN_CYCLES → HALT. flush_i counted, no state change.
- HALT: halted_o=1, pc_incr_en_o=0, if_stall_o=id_stall_o=1; resume_i & ~halt_req_i & ~err_o → RUN. err_o cleared only by rst.
- stall_cnt increments each cycle if_stall_o=1 in RUN or BUSY; both counters saturate at 2^CNT_W-1.

## Timing
- Reset (async assert): state=BOOT, all counters 0, err_o=0; outputs: pc_incr_en_o=0, if_stall_o=id_stall_o=1, id_flush_o=ex_bubble_o=halted_o=0, state_o=BOOT.
- Control outputs are Mealy: combinational from registered state and current inputs, zero-cycle latency to flush_i/lu/ex_busy_i.
- State, timers, counters, err_o update on rising clk.
- First pc_incr_en_o=1 on cycle BOOT_CYCLES after reset release.
- flush_i and lu same cycle: flush wins (lu instruction is flushed), no stall counted.
- halt_req_i deasserted during DRAIN: DRAIN completes, HALT exits immediately on next resume_i.
- rst mid-operation: immediate return to BOOT; counters cleared.

## Structure
- pipe_state_t (3-bit enum) and parameter defaults in core package; state_o typed pipe_state_t.
- Sub-module hazard_detect: combinational lu comparator.
- Counters inline (two instances of same saturating logic).

## Test plan
- Reset, then idle inputs → pc_incr_en_o rises on cycle 2 after release; state BOOT→RUN.
- ex_mem_read_i=1, ex_rd_i=5, id_rs1_i=5, id_rs1_used_i=1 for one cycle → one cycle stall+bubble, stall_cnt=1; ex_rd_i=0 same case → no stall.
- flush_i pulse in RUN → id_flush_o high 2 cycles, flush_cnt=1; second flush_i in FLUSH → 2 more cycles, flush_cnt=2.
- ex_busy_i high 5 cycles → 5 stall cycles, ex_bubble_o=0, stall_cnt=5; high 64 cycles → err_o=1, halted_o=1, resume_i ignored.
- halt_req_i pulse → 2 DRAIN bubble cycles, halted_o=1; resume_i → RUN, pc_incr_en_o=1 next cycle.
- flush_i and lu same cycle → id_flush_o=1, stall_cnt unchanged; CNT_W=4 with 20 stalls → stall_cnt=15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and parameter defaults for the pipeline sequencing controller.
package pipe_ctrl_pkg;

  localparam int BOOT_CYCLES_DEF  = 2;
  localparam int FLUSH_CYCLES_DEF = 2;
  localparam int DRAIN_CYCLES_DEF = 2;
  localparam int BUSY_TIMEOUT_DEF = 64;
  localparam int CNT_W_DEF        = 16;
  localparam int REG_ADDR_W       = 5;

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_RUN   = 3'd1,
    ST_FLUSH = 3'd2,
    ST_BUSY  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_HALT  = 3'd5
  } pipe_state_t;

  typedef struct packed {
    logic pc_incr_en;
    logic if_stall;
    logic id_stall;
    logic id_flush;
    logic ex_bubble;
  } ctrl_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline-side signal bundle of pipe_ctrl: hazard/debug inputs, stage controls,
// status and performance counters.
interface pipe_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);

  logic                  flush_i;
  logic                  ex_busy_i;
  logic                  ex_mem_read_i;
  logic [REG_ADDR_W-1:0] ex_rd_i;
  logic [REG_ADDR_W-1:0] id_rs1_i;
  logic [REG_ADDR_W-1:0] id_rs2_i;
  logic                  id_rs1_used_i;
  logic                  id_rs2_used_i;
  logic                  halt_req_i;
  logic                  resume_i;

  logic                  pc_incr_en_o;
  logic                  if_stall_o;
  logic                  id_stall_o;
  logic                  id_flush_o;
  logic                  ex_bubble_o;
  logic                  halted_o;
  logic                  err_o;
  pipe_state_t           state_o;
  logic [CNT_W-1:0]      stall_cnt_o;
  logic [CNT_W-1:0]      flush_cnt_o;

  modport master (
    input  flush_i, ex_busy_i, ex_mem_read_i, ex_rd_i, id_rs1_i, id_rs2_i,
           id_rs1_used_i, id_rs2_used_i, halt_req_i, resume_i,
    output pc_incr_en_o, if_stall_o, id_stall_o, id_flush_o, ex_bubble_o,
           halted_o, err_o, state_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    output flush_i, ex_busy_i, ex_mem_read_i, ex_rd_i, id_rs1_i, id_rs2_i,
           id_rs1_used_i, id_rs2_used_i, halt_req_i, resume_i,
    input  pc_incr_en_o, if_stall_o, id_stall_o, id_flush_o, ex_bubble_o,
           halted_o, err_o, state_o, stall_cnt_o, flush_cnt_o
  );

endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use comparator: the ID instruction reads a register the load in EX has
// not yet produced.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic                  i_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic                  i_id_rs1_used,
  input  logic                  i_id_rs2_used,
  output logic                  o_lu
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit = i_id_rs1_used && (i_id_rs1 == i_ex_rd);
  assign w_rs2_hit = i_id_rs2_used && (i_id_rs2 == i_ex_rd);
  // x0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign o_lu      = i_ex_mem_read && (i_ex_rd != '0) && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: arbitrates branch flush, EX busy, load-use and
// debug halt into PC/IF/ID/EX controls, with saturating stall/flush counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int BOOT_CYCLES  = BOOT_CYCLES_DEF,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.master io_pipe
);

  localparam int TMR_MAX = max_int(max_int(BOOT_CYCLES, FLUSH_CYCLES),
                                   max_int(DRAIN_CYCLES, BUSY_TIMEOUT));
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  typedef logic [TMR_W-1:0] tmr_t;

  pipe_state_t      r_state;
  pipe_state_t      w_state_nxt;
  tmr_t             r_tmr;
  tmr_t             w_tmr_nxt;
  logic             r_err;
  logic             w_err_set;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_lu;
  logic             w_run_arb;
  logic             w_flush_inc;
  logic             w_stall_inc;
  ctrl_t            w_ctrl;

  hazard_detect u_hazard (
    .i_ex_mem_read (io_pipe.ex_mem_read_i),
    .i_ex_rd       (io_pipe.ex_rd_i),
    .i_id_rs1      (io_pipe.id_rs1_i),
    .i_id_rs2      (io_pipe.id_rs2_i),
    .i_id_rs1_used (io_pipe.id_rs1_used_i),
    .i_id_rs2_used (io_pipe.id_rs2_used_i),
    .o_lu          (w_lu)
  );

  // BUSY hands control back to the RUN arbiter in the very cycle ex_busy_i drops.
  assign w_run_arb = (r_state == ST_RUN) ||
                     ((r_state == ST_BUSY) && !io_pipe.ex_busy_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_BOOT;
      r_tmr   <= '0;
      r_err   <= 1'b0;
    end else begin
      // NOTE: state registers use <= so every flop samples the pre-edge values.
      r_state <= w_state_nxt;
      r_tmr   <= w_tmr_nxt;
      if (w_err_set) r_err <= 1'b1;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr;
    w_err_set   = 1'b0;
    w_flush_inc = 1'b0;
    if (w_run_arb) begin
      w_state_nxt = ST_RUN;
      if (io_pipe.flush_i) begin
        w_flush_inc = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          w_state_nxt = ST_FLUSH;
          w_tmr_nxt   = tmr_t'(FLUSH_CYCLES - 1);
        end
      end else if (io_pipe.ex_busy_i) begin
        w_state_nxt = ST_BUSY;
        w_tmr_nxt   = tmr_t'(1);
      end else if (!w_lu && io_pipe.halt_req_i) begin
        w_state_nxt = ST_DRAIN;
        w_tmr_nxt   = tmr_t'(1);
      end
    end else begin
      case (r_state)
        ST_BOOT: begin
          if (r_tmr == tmr_t'(BOOT_CYCLES - 1)) begin
            w_state_nxt = ST_RUN;
            w_tmr_nxt   = '0;
          end else begin
            w_tmr_nxt = r_tmr + 1'b1;
          end
        end
        ST_FLUSH: begin
          if (io_pipe.flush_i) begin
            w_flush_inc = 1'b1;
            w_tmr_nxt   = tmr_t'(FLUSH_CYCLES - 1);
          end else if (r_tmr <= tmr_t'(1)) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_tmr_nxt = r_tmr - 1'b1;
          end
        end
        ST_BUSY: begin
          // The RUN entry cycle counted as busy cycle 1, so this is cycle r_tmr+1.
          if (r_tmr >= tmr_t'(BUSY_TIMEOUT - 1)) begin
            w_err_set   = 1'b1;
            w_state_nxt = ST_HALT;
          end else begin
            w_tmr_nxt = r_tmr + 1'b1;
          end
        end
        ST_DRAIN: begin
          w_flush_inc = io_pipe.flush_i;
          if (r_tmr >= tmr_t'(DRAIN_CYCLES)) w_state_nxt = ST_HALT;
          else                               w_tmr_nxt   = r_tmr + 1'b1;
        end
        ST_HALT: begin
          if (io_pipe.resume_i && !io_pipe.halt_req_i && !r_err) w_state_nxt = ST_RUN;
        end
        ST_RUN:  ;
        default: w_state_nxt = ST_BOOT;
      endcase
    end
  end

  always_comb begin
    w_ctrl = '0;
    if (w_run_arb) begin
      if (io_pipe.flush_i) begin
        w_ctrl.pc_incr_en = 1'b1;
        w_ctrl.id_flush   = 1'b1;
        w_ctrl.ex_bubble  = 1'b1;
      end else if (io_pipe.ex_busy_i) begin
        w_ctrl.if_stall = 1'b1;
        w_ctrl.id_stall = 1'b1;
      end else if (w_lu) begin
        w_ctrl.if_stall  = 1'b1;
        w_ctrl.id_stall  = 1'b1;
        w_ctrl.ex_bubble = 1'b1;
      end else if (io_pipe.halt_req_i) begin
        w_ctrl.if_stall = 1'b1;
        w_ctrl.id_flush = 1'b1;
      end else begin
        w_ctrl.pc_incr_en = 1'b1;
      end
    end else begin
      case (r_state)
        ST_FLUSH: begin
          w_ctrl.pc_incr_en = 1'b1;
          w_ctrl.id_flush   = 1'b1;
          w_ctrl.ex_bubble  = 1'b1;
        end
        ST_DRAIN: begin
          w_ctrl.if_stall  = 1'b1;
          w_ctrl.id_flush  = 1'b1;
          w_ctrl.ex_bubble = 1'b1;
        end
        ST_RUN:  w_ctrl.pc_incr_en = 1'b1;
        default: begin
          w_ctrl.if_stall = 1'b1;
          w_ctrl.id_stall = 1'b1;
        end
      endcase
    end
  end

  assign w_stall_inc = w_ctrl.if_stall && ((r_state == ST_RUN) || (r_state == ST_BUSY));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_inc && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush_inc && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign io_pipe.pc_incr_en_o = w_ctrl.pc_incr_en;
  assign io_pipe.if_stall_o   = w_ctrl.if_stall;
  assign io_pipe.id_stall_o   = w_ctrl.id_stall;
  assign io_pipe.id_flush_o   = w_ctrl.id_flush;
  assign io_pipe.ex_bubble_o  = w_ctrl.ex_bubble;
  assign io_pipe.halted_o     = (r_state == ST_HALT);
  assign io_pipe.err_o        = r_err;
  assign io_pipe.state_o      = r_state;
  assign io_pipe.stall_cnt_o  = r_stall_cnt;
  assign io_pipe.flush_cnt_o  = r_flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed per-cycle vectors push expected
// outputs, a negedge monitor pops and compares (plus a CNT_W=4 twin for saturation).
module tb_pipe_ctrl
  import pipe_ctrl_pkg::*;
;

  typedef struct packed {
    logic       mr;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
  } lu_t;

  typedef struct {
    string      name;
    logic [9:0] vec;   // {pc, if_stall, id_stall, id_flush, ex_bubble, halted, err, state}
    int         sc;
    int         fc;
  } exp_t;

  // Control vectors {pc_incr_en, if_stall, id_stall, id_flush, ex_bubble}
  localparam logic [4:0] C_IDLE  = 5'b10000;
  localparam logic [4:0] C_STALL = 5'b01100;
  localparam logic [4:0] C_FLUSH = 5'b10011;
  localparam logic [4:0] C_LU    = 5'b01101;
  localparam logic [4:0] C_HREQ  = 5'b01010;
  localparam logic [4:0] C_DRAIN = 5'b01011;
  localparam lu_t        LU_NONE = '0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];
  exp_t x;

  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(16)) bus_a ();
  pipe_ctrl_if #(.CNT_W(4))  bus_b ();

  assign bus_b.flush_i       = bus_a.flush_i;
  assign bus_b.ex_busy_i     = bus_a.ex_busy_i;
  assign bus_b.ex_mem_read_i = bus_a.ex_mem_read_i;
  assign bus_b.ex_rd_i       = bus_a.ex_rd_i;
  assign bus_b.id_rs1_i      = bus_a.id_rs1_i;
  assign bus_b.id_rs2_i      = bus_a.id_rs2_i;
  assign bus_b.id_rs1_used_i = bus_a.id_rs1_used_i;
  assign bus_b.id_rs2_used_i = bus_a.id_rs2_used_i;
  assign bus_b.halt_req_i    = bus_a.halt_req_i;
  assign bus_b.resume_i      = bus_a.resume_i;

  pipe_ctrl #(.CNT_W(16)) u_dut (.clk(clk), .rst(rst), .io_pipe(bus_a));
  pipe_ctrl #(.CNT_W(4))  u_dut4 (.clk(clk), .rst(rst), .io_pipe(bus_b));

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
  endtask

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  function automatic lu_t mk_lu(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic u1, input logic u2);
    return '{mr, rd, rs1, rs2, u1, u2};
  endfunction

  task automatic push(input string nm, input logic [4:0] c, input pipe_state_t s,
                      input int sc, input int fc, input logic e);
    exp_t r;
    r.name = nm;
    r.vec  = {c, (s == ST_HALT), e, s};
    r.sc   = sc;
    r.fc   = fc;
    sb.push_back(r);
  endtask

  task automatic drive(input lu_t l, input logic f, input logic b, input logic h, input logic r);
    bus_a.ex_mem_read_i = l.mr;
    bus_a.ex_rd_i       = l.rd;
    bus_a.id_rs1_i      = l.rs1;
    bus_a.id_rs2_i      = l.rs2;
    bus_a.id_rs1_used_i = l.u1;
    bus_a.id_rs2_used_i = l.u2;
    bus_a.flush_i       = f;
    bus_a.ex_busy_i     = b;
    bus_a.halt_req_i    = h;
    bus_a.resume_i      = r;
  endtask

  // One cycle: apply inputs just after the edge and queue what that cycle must show.
  task automatic cyc(input string nm, input lu_t l, input logic f, input logic b,
                     input logic h, input logic r, input logic [4:0] c, input pipe_state_t s,
                     input int sc = -1, input int fc = -1, input logic e = 1'b0);
    @(posedge clk);
    #1;
    drive(l, f, b, h, r);
    push(nm, c, s, sc, fc, e);
  endtask

  task automatic reset_seq();
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(LU_NONE, 0, 0, 0, 0);
    push("reset", C_STALL, ST_BOOT, 0, 0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    push("boot_c0", C_STALL, ST_BOOT, 0, 0, 1'b0);
    cyc("boot_c1", LU_NONE, 0, 0, 0, 0, C_STALL, ST_BOOT, 0, 0);
    cyc("run_c2",  LU_NONE, 0, 0, 0, 0, C_IDLE,  ST_RUN,  0, 0);
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      x = sb.pop_front();
      check({x.name, ".ctrl"}, 32'({bus_a.pc_incr_en_o, bus_a.if_stall_o, bus_a.id_stall_o,
             bus_a.id_flush_o, bus_a.ex_bubble_o, bus_a.halted_o, bus_a.err_o, bus_a.state_o}),
            32'(x.vec));
      check({x.name, ".ctrl4"}, 32'({bus_b.pc_incr_en_o, bus_b.if_stall_o, bus_b.id_stall_o,
             bus_b.id_flush_o, bus_b.ex_bubble_o, bus_b.halted_o, bus_b.err_o, bus_b.state_o}),
            32'(x.vec));
      if (x.sc >= 0) begin
        check({x.name, ".stall_cnt"},  32'(bus_a.stall_cnt_o), 32'(x.sc));
        check({x.name, ".stall_cnt4"}, 32'(bus_b.stall_cnt_o), 32'(sat15(x.sc)));
      end
      if (x.fc >= 0) begin
        check({x.name, ".flush_cnt"},  32'(bus_a.flush_cnt_o), 32'(x.fc));
        check({x.name, ".flush_cnt4"}, 32'(bus_b.flush_cnt_o), 32'(sat15(x.fc)));
      end
    end
  end

  initial begin
    drive(LU_NONE, 0, 0, 0, 0);
    reset_seq();

    // Load-use detection and its qualifiers
    cyc("lu_rs1",     mk_lu(1, 5, 5, 0, 1, 0), 0, 0, 0, 0, C_LU,   ST_RUN, 0, 0);
    cyc("lu_after",   LU_NONE,                 0, 0, 0, 0, C_IDLE, ST_RUN, 1, 0);
    cyc("lu_rd0",     mk_lu(1, 0, 0, 0, 1, 0), 0, 0, 0, 0, C_IDLE, ST_RUN, 1, 0);
    cyc("lu_rs2",     mk_lu(1, 7, 0, 7, 0, 1), 0, 0, 0, 0, C_LU,   ST_RUN, 1, 0);
    cyc("lu_unused",  mk_lu(1, 7, 7, 7, 0, 0), 0, 0, 0, 0, C_IDLE, ST_RUN, 2, 0);
    cyc("lu_noload",  mk_lu(0, 5, 5, 0, 1, 0), 0, 0, 0, 0, C_IDLE, ST_RUN, 2, 0);

    // Branch flush, then a second flush while in FLUSH reloads the window
    cyc("fl_run",     LU_NONE, 1, 0, 0, 0, C_FLUSH, ST_RUN,   2, 0);
    cyc("fl_reload",  LU_NONE, 1, 0, 0, 0, C_FLUSH, ST_FLUSH, 2, 1);
    cyc("fl_tail",    LU_NONE, 0, 0, 0, 0, C_FLUSH, ST_FLUSH, 2, 2);
    cyc("fl_done",    LU_NONE, 0, 0, 0, 0, C_IDLE,  ST_RUN,   2, 2);

    // Flush beats load-use in the same cycle; no stall counted
    cyc("fl_lu",      mk_lu(1, 5, 5, 0, 1, 0), 1, 0, 0, 0, C_FLUSH, ST_RUN, 2, 2);
    cyc("fl_lu_tail", LU_NONE, 0, 0, 0, 0, C_FLUSH, ST_FLUSH, 2, 3);
    cyc("fl_lu_done", LU_NONE, 0, 0, 0, 0, C_IDLE,  ST_RUN,   2, 3);

    // Five busy cycles; a flush inside BUSY is ignored; Mealy release
    cyc("busy1",      LU_NONE, 0, 1, 0, 0, C_STALL, ST_RUN,  2, 3);
    cyc("busy2",      LU_NONE, 0, 1, 0, 0, C_STALL, ST_BUSY, 3, 3);
    cyc("busy3_fl",   LU_NONE, 1, 1, 0, 0, C_STALL, ST_BUSY, 4, 3);
    cyc("busy4",      LU_NONE, 0, 1, 0, 0, C_STALL, ST_BUSY, 5, 3);
    cyc("busy5",      LU_NONE, 0, 1, 0, 0, C_STALL, ST_BUSY, 6, 3);
    cyc("busy_rel",   LU_NONE, 0, 0, 0, 0, C_IDLE,  ST_BUSY, 7, 3);
    cyc("busy_done",  LU_NONE, 0, 0, 0, 0, C_IDLE,  ST_RUN,  7, 3);

    // Halt pulse: two drain bubbles, flush counted in DRAIN, resume gated by halt_req
    cyc("halt_req",   LU_NONE, 0, 0, 1, 0, C_HREQ,  ST_RUN,   7, 3);
    cyc("drain1",     LU_NONE, 0, 0, 0, 0, C_DRAIN, ST_DRAIN, 8, 3);
    cyc("drain2_fl",  LU_NONE, 1, 0, 0, 0, C_DRAIN, ST_DRAIN, 8, 3);
    cyc("halt",       LU_NONE, 0, 0, 0, 0, C_STALL, ST_HALT,  8, 4);
    cyc("halt_hold",  LU_NONE, 0, 0, 1, 1, C_STALL, ST_HALT,  8, 4);
    cyc("resume",     LU_NONE, 0, 0, 0, 1, C_STALL, ST_HALT,  8, 4);
    cyc("resumed",    LU_NONE, 0, 0, 0, 0, C_IDLE,  ST_RUN,   8, 4);

    // Busy timeout: 64 consecutive busy cycles -> sticky error and HALT
    cyc("to_entry",   LU_NONE, 0, 1, 0, 0, C_STALL, ST_RUN, 8, 4);
    for (int i = 1; i <= 63; i++)
      cyc($sformatf("to_busy%0d", i), LU_NONE, 0, 1, 0, 0, C_STALL, ST_BUSY, 8 + i, 4);
    cyc("to_halt",    LU_NONE, 0, 0, 0, 1, C_STALL, ST_HALT, 72, 4, 1'b1);
    cyc("to_noresume",LU_NONE, 0, 0, 0, 1, C_STALL, ST_HALT, 72, 4, 1'b1);
    cyc("to_stuck",   LU_NONE, 0, 0, 0, 0, C_STALL, ST_HALT, 72, 4, 1'b1);

    // Reset mid-operation clears everything and reboots
    reset_seq();
    cyc("post_rst",   LU_NONE, 1, 0, 0, 0, C_FLUSH, ST_RUN, 0, 0);

    for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
